// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port (read-only) and a data port (read/write). Each transaction walks
// IDLE -> ACCESS (LAT cycles) -> RESP, with the owner's ack pulsing in RESP.
// Optional build macro MEM_PORT_ARBITER_RR_EN switches contention handling from
// fixed data-over-instruction priority to alternating (round-robin) grants.
module mem_port_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_Address,
  output logic [31:0] mem_WriteData,
  output logic        mem_ReadCtrl,
  output logic        mem_WriteCtrl,
  input  logic [31:0] mem_OutputData,
  output logic        busy,
  output logic        grant_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

  // Counter value of the final ACCESS cycle, and of the cycle just before it
  // (the latter only matters when LAT >= 2, where the write strobe is raised
  // one edge ahead so it is high exactly during the last ACCESS cycle).
  localparam logic [3:0] LastCount    = 4'(LAT - 1);
  localparam logic [3:0] PreLastCount = 4'(LAT - 2);

  stateT      state;
  logic [3:0] accessCount;
  logic       writeTxn;
  logic       grantData;

  // Winner of an IDLE-cycle arbitration: 1 selects the data port.
  always_comb begin
    grantData = 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
    grantData = d_req && (!i_req || !grant_d);
`else
    grantData = d_req;
`endif
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      accessCount   <= 4'd0;
      writeTxn      <= 1'b0;
      busy          <= 1'b0;
      grant_d       <= 1'b0;
      i_ack         <= 1'b0;
      d_ack         <= 1'b0;
      i_rdata       <= 32'd0;
      d_rdata       <= 32'd0;
      mem_Address   <= 32'd0;
      mem_WriteData <= 32'd0;
      mem_ReadCtrl  <= 1'b0;
      mem_WriteCtrl <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          if (i_req || d_req) begin
            state         <= ACCESS;
            busy          <= 1'b1;
            accessCount   <= 4'd0;
            grant_d       <= grantData;
            writeTxn      <= grantData && d_we;
            mem_Address   <= grantData ? d_addr : i_addr;
            mem_ReadCtrl  <= !(grantData && d_we);
            mem_WriteCtrl <= grantData && d_we && (LAT == 1);
            if (grantData) begin
              mem_WriteData <= d_wdata;
            end
          end
        end
        ACCESS: begin
          if (accessCount == LastCount) begin
            state         <= RESP;
            mem_ReadCtrl  <= 1'b0;
            mem_WriteCtrl <= 1'b0;
            if (grant_d) begin
              d_ack <= 1'b1;
              if (!writeTxn) begin
                d_rdata <= mem_OutputData;
              end
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_OutputData;
            end
          end else begin
            accessCount   <= accessCount + 4'd1;
            mem_WriteCtrl <= writeTxn && (accessCount == PreLastCount);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          i_ack <= 1'b0;
          d_ack <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives four arbiter instances (LAT = 1, 2, 3, 15), each
// with its own behavioural memory, through table vectors, hand-written corner
// sequences and randomized traffic scored against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NumInst = 4;

`ifdef MEM_PORT_ARBITER_RR_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  function automatic int latOf(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  logic        clk;
  logic        rstN   [NumInst];
  logic        iReq   [NumInst];
  logic [31:0] iAddr  [NumInst];
  logic        dReq   [NumInst];
  logic        dWe    [NumInst];
  logic [31:0] dAddr  [NumInst];
  logic [31:0] dWdata [NumInst];
  logic        iAck   [NumInst];
  logic        dAck   [NumInst];
  logic [31:0] iRdata [NumInst];
  logic [31:0] dRdata [NumInst];
  logic [31:0] memAddr  [NumInst];
  logic [31:0] memWdata [NumInst];
  logic        memRd  [NumInst];
  logic        memWr  [NumInst];
  logic [31:0] memOut [NumInst];
  logic        busy   [NumInst];
  logic        grantD [NumInst];

  logic [31:0] mem [NumInst][256];
  logic [7:0]  memIdx [NumInst];
  int          writeCount [NumInst] = '{0, 0, 0, 0};
  logic [31:0] lastWriteAddr [NumInst];
  logic        preloadEn;
  int          preloadInst;
  logic [7:0]  preloadAddr;
  logic [31:0] preloadData;

  logic [31:0] modelMem [NumInst][16];
  logic        lastGrantD [NumInst];
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    int          inst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        expD;
    logic        expWrite;
    logic [31:0] expData;
  } vecT;

  vecT vecs [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read path, one per instance.
  always_comb begin
    for (int k = 0; k < NumInst; k++) begin
      memIdx[k] = 8'(memAddr[k] % 32'd256);
      memOut[k] = mem[k][memIdx[k]];
    end
  end

  // Memory writes from the arbiters, plus bench preloading.
  always @(posedge clk) begin
    if (preloadEn) mem[preloadInst][preloadAddr] <= preloadData;
    for (int k = 0; k < NumInst; k++) begin
      if (memWr[k]) begin
        mem[k][memIdx[k]] <= memWdata[k];
        writeCount[k]     <= writeCount[k] + 1;
        lastWriteAddr[k]  <= memAddr[k];
      end
    end
  end

  generate
    for (genvar g = 0; g < NumInst; g++) begin : gInst
      mem_port_arbiter #(.LAT(latOf(g))) dut (
        .clk            (clk),
        .rst_n          (rstN[g]),
        .i_req          (iReq[g]),
        .i_addr         (iAddr[g]),
        .i_ack          (iAck[g]),
        .i_rdata        (iRdata[g]),
        .d_req          (dReq[g]),
        .d_we           (dWe[g]),
        .d_addr         (dAddr[g]),
        .d_wdata        (dWdata[g]),
        .d_ack          (dAck[g]),
        .d_rdata        (dRdata[g]),
        .mem_Address    (memAddr[g]),
        .mem_WriteData  (memWdata[g]),
        .mem_ReadCtrl   (memRd[g]),
        .mem_WriteCtrl  (memWr[g]),
        .mem_OutputData (memOut[g]),
        .busy           (busy[g]),
        .grant_d        (grantD[g])
      );
    end
  endgenerate

  // Arbitration rule: data wins contention unless alternating mode hands the
  // turn to the port that was not granted last.
  function automatic logic pickData(input logic ir, input logic dr, input logic lastD);
    if (ir && dr && RrMode) return !lastD;
    return dr;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] dd);
    iReq[k]   = ir;
    iAddr[k]  = ia;
    dReq[k]   = dr;
    dWe[k]    = dw;
    dAddr[k]  = da;
    dWdata[k] = dd;
  endtask

  task automatic preloadWord(input int k, input int a, input logic [31:0] d);
    preloadEn   = 1'b1;
    preloadInst = k;
    preloadAddr = 8'(a);
    preloadData = d;
    @(posedge clk);
    #1 preloadEn = 1'b0;
  endtask

  task automatic checkResetState(input int k);
    string p;
    p = $sformatf("reset[%0d]", k);
    checkOutput({p, ".busy"}, 32'(busy[k]), 32'd0);
    checkOutput({p, ".acks"}, 32'({iAck[k], dAck[k]}), 32'd0);
    checkOutput({p, ".grantD"}, 32'(grantD[k]), 32'd0);
    checkOutput({p, ".strobes"}, 32'({memRd[k], memWr[k]}), 32'd0);
    checkOutput({p, ".iRdata"}, iRdata[k], 32'd0);
    checkOutput({p, ".dRdata"}, dRdata[k], 32'd0);
    checkOutput({p, ".memAddr"}, memAddr[k], 32'd0);
    checkOutput({p, ".memWdata"}, memWdata[k], 32'd0);
  endtask

  // Holds an instance in reset for a cycle, checks it, releases just after an edge.
  task automatic resetInst(input int k);
    rstN[k] = 1'b0;
    applyStimulus(k, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    lastGrantD[k] = 1'b0;
    @(negedge clk);
    checkResetState(k);
    @(posedge clk);
    #1 rstN[k] = 1'b1;
  endtask

  // One transaction from the grant edge to the RESP cycle. Called just after
  // an edge with the instance in IDLE and requests already driven.
  task automatic runRound(input int k, input logic expD, input logic [31:0] expAddr,
                          input logic [31:0] expData, input logic isWrite,
                          input logic dropEarly, input string tag);
    int lat;
    int wc0;
    string p;
    lat = latOf(k);
    wc0 = writeCount[k];
    p = $sformatf("%s[%0d]", tag, k);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk);
      if (c == 1 && dropEarly) begin
        #1;
        applyStimulus(k, 1'b0, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h1234_5678);
      end
      @(negedge clk);
      checkOutput({p, ".earlyAck"}, 32'({iAck[k], dAck[k]}), 32'd0);
      checkOutput({p, ".busy"}, 32'(busy[k]), 32'd1);
      checkOutput({p, ".memAddr"}, memAddr[k], expAddr);
      checkOutput({p, ".strobes"}, 32'({memRd[k], memWr[k]}),
                  32'({!isWrite, isWrite && (c == lat)}));
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({p, ".ack"}, 32'({iAck[k], dAck[k]}), expD ? 32'd1 : 32'd2);
    checkOutput({p, ".grantD"}, 32'(grantD[k]), 32'(expD));
    checkOutput({p, ".respStrobes"}, 32'({memRd[k], memWr[k]}), 32'd0);
    if (isWrite) checkOutput({p, ".writeAddr"}, lastWriteAddr[k], expAddr);
    else checkOutput({p, ".rdata"}, expD ? dRdata[k] : iRdata[k], expData);
    checkOutput({p, ".writes"}, 32'(writeCount[k] - wc0), 32'(isWrite));
    lastGrantD[k] = expD;
  endtask

  // Crosses the RESP->IDLE edge and confirms the instance went idle.
  task automatic finishRound(input int k, input string tag);
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s[%0d].idleBusy", tag, k), 32'(busy[k]), 32'd0);
    checkOutput($sformatf("%s[%0d].idleAck", tag, k), 32'({iAck[k], dAck[k]}), 32'd0);
  endtask

  initial begin
    logic        expD;
    logic        expW;
    logic [31:0] expAddr;
    logic [2:0]  order;
    logic        iP, dP, dW;
    logic [31:0] iA, dA, dD;

    preloadEn = 1'b0;
    for (int k = 0; k < NumInst; k++) begin
      rstN[k] = 1'b1;
      applyStimulus(k, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      lastGrantD[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < NumInst; k++) rstN[k] = 1'b0;

    for (int k = 0; k < NumInst; k++)
      for (int a = 0; a < 16; a++) modelMem[k][a] = $urandom;
    modelMem[0][4] = 32'h8C22_0000;
    modelMem[1][7] = 32'h1234_5678;
    modelMem[2][5] = 32'hA5A5_A5A5;
    for (int k = 0; k < NumInst; k++)
      for (int a = 0; a < 16; a++) preloadWord(k, a, modelMem[k][a]);

    for (int k = 0; k < NumInst; k++) resetInst(k);

    // Single-port transactions: {inst, ir, ia, dr, dw, da, dd, expD, expWrite, expData}
    vecs[0]  = '{0, 1'b1, 32'd4,  1'b0, 1'b0, 32'd0,  32'd0,          1'b0, 1'b0, 32'h8C22_0000};
    vecs[1]  = '{0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd9,  32'h0001_0001,  1'b1, 1'b1, 32'd0};
    vecs[2]  = '{0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd9,  32'd0,          1'b1, 1'b0, 32'h0001_0001};
    vecs[3]  = '{1, 1'b1, 32'd7,  1'b0, 1'b0, 32'd0,  32'd0,          1'b0, 1'b0, 32'h1234_5678};
    vecs[4]  = '{1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd7,  32'hDEAD_BEEF,  1'b1, 1'b1, 32'd0};
    vecs[5]  = '{1, 1'b1, 32'd7,  1'b0, 1'b0, 32'd0,  32'd0,          1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{2, 1'b0, 32'd0,  1'b1, 1'b0, 32'd5,  32'd0,          1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[7]  = '{2, 1'b0, 32'd0,  1'b1, 1'b1, 32'd15, 32'hCAFE_F00D,  1'b1, 1'b1, 32'd0};
    vecs[8]  = '{2, 1'b1, 32'd15, 1'b0, 1'b0, 32'd0,  32'd0,          1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{3, 1'b0, 32'd0,  1'b1, 1'b1, 32'd3,  32'h0F0F_0F0F,  1'b1, 1'b1, 32'd0};
    vecs[10] = '{3, 1'b1, 32'd3,  1'b0, 1'b0, 32'd0,  32'd0,          1'b0, 1'b0, 32'h0F0F_0F0F};

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].inst, vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].dw, vecs[v].da, vecs[v].dd);
      runRound(vecs[v].inst, vecs[v].expD, vecs[v].expD ? vecs[v].da : vecs[v].ia,
               vecs[v].expData, vecs[v].expWrite, 1'b0, $sformatf("vec%0d", v));
      if (vecs[v].expWrite) modelMem[vecs[v].inst][4'(vecs[v].da)] = vecs[v].dd;
      applyStimulus(vecs[v].inst, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      finishRound(vecs[v].inst, $sformatf("vec%0d", v));
    end

    // Both ports held for three transactions, then the data port backs off.
    resetInst(1);
    order = 3'b000;
    applyStimulus(1, 1'b1, 32'd4, 1'b1, 1'b0, 32'd8, 32'd0);
    for (int r = 0; r < 3; r++) begin
      expD = pickData(1'b1, 1'b1, lastGrantD[1]);
      expAddr = expD ? 32'd8 : 32'd4;
      runRound(1, expD, expAddr, modelMem[1][4'(expAddr)], 1'b0, 1'b0, $sformatf("contend%0d", r));
      order = {order[1:0], dAck[1]};
      if (r == 2) dReq[1] = 1'b0;
      finishRound(1, "contend");
    end
    checkOutput("contend.order", 32'(order), RrMode ? 32'd5 : 32'd7);
    runRound(1, 1'b0, 32'd4, modelMem[1][4], 1'b0, 1'b0, "pendingLoser");
    iReq[1] = 1'b0;
    finishRound(1, "pendingLoser");

    // Reset during the second ACCESS cycle of a LAT=3 write.
    begin
      int wc0;
      wc0 = writeCount[2];
      applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'h5555_AAAA);
      @(posedge clk);
      @(posedge clk);
      #2 rstN[2] = 1'b0;
      #1;
      checkOutput("midReset.busy", 32'(busy[2]), 32'd0);
      checkOutput("midReset.strobes", 32'({memRd[2], memWr[2]}), 32'd0);
      checkOutput("midReset.memAddr", memAddr[2], 32'd0);
      dReq[2] = 1'b0;
      dWe[2] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checkOutput("midReset.acks", 32'({iAck[2], dAck[2]}), 32'd0);
      end
      checkOutput("midReset.writes", 32'(writeCount[2] - wc0), 32'd0);
      checkOutput("midReset.mem5", mem[2][5], modelMem[2][5]);
      @(posedge clk);
      #1 rstN[2] = 1'b1;
      lastGrantD[2] = 1'b0;
      applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
      runRound(2, 1'b1, 32'd5, modelMem[2][5], 1'b0, 1'b0, "afterReset");
      dReq[2] = 1'b0;
      finishRound(2, "afterReset");
    end

    // Data request withdrawn one cycle after its grant still completes once.
    applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b0, 32'd15, 32'd0);
    runRound(2, 1'b1, 32'd15, modelMem[2][15], 1'b0, 1'b1, "dropAfterGrant");
    finishRound(2, "dropAfterGrant");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("dropAfterGrant.noRepeat", 32'({iAck[2], dAck[2], busy[2]}), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic against the transaction-level model.
    for (int k = 0; k < NumInst; k++) begin
      iP = 1'b0;
      dP = 1'b0;
      iA = 32'd0;
      dA = 32'd0;
      dW = 1'b0;
      dD = 32'd0;
      for (int r = 0; r < 20; r++) begin
        if (!iP) begin
          iP = 1'($urandom_range(0, 1));
          iA = $urandom_range(0, 15);
        end
        if (!dP) begin
          dP = 1'($urandom_range(0, 1));
          dA = $urandom_range(0, 15);
          dW = 1'($urandom_range(0, 1));
          dD = $urandom;
        end
        if (!iP && !dP) dP = 1'b1;
        applyStimulus(k, iP, iA, dP, dW, dA, dD);
        expD = pickData(iP, dP, lastGrantD[k]);
        expW = expD && dW;
        expAddr = expD ? dA : iA;
        runRound(k, expD, expAddr, modelMem[k][4'(expAddr)], expW, 1'b0, $sformatf("rand%0d", r));
        if (expW) modelMem[k][4'(dA)] = dD;
        if (expD) dP = 1'b0;
        else iP = 1'b0;
        applyStimulus(k, iP, iA, dP, dW, dA, dD);
        finishRound(k, "rand");
      end
      applyStimulus(k, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory access cycles per transaction (1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction-fetch port request, read-only.
REQ-005 i_addr  input  32  instruction-fetch word address.
REQ-006 i_ack  output  1  one-cycle pulse; i_rdata valid this cycle.
REQ-007 i_rdata  output  32  fetched word, held until next i_ack.
REQ-008 d_req  input  1  data port request.
REQ-009 d_we  input  1  data port write (1) / read (0).
REQ-010 d_addr  input  32  data word address.
REQ-011 d_wdata  input  32  data write value.
REQ-012 d_ack  output  1  one-cycle completion pulse.
REQ-013 d_rdata  output  32  read result, held until next read d_ack.
REQ-014 mem_Address, mem_WriteData  output  32 each  to shared single-port memory.
REQ-015 mem_ReadCtrl, mem_WriteCtrl  output  1 each  memory strobes.
REQ-016 mem_OutputData  input  32  memory read data, combinational from mem_Address.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 grant_d  output  1  owner of current/last grant: 1 data, 0 instruction.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when i_req|d_req, ACCESS->RESP when counter reaches LAT-1, RESP->IDLE always.
REQ-020 Grant decided only in IDLE; owner, address, write flag, write data latched on the IDLE->ACCESS edge.
REQ-021 Default arbitration: d_req wins over i_req when both high in IDLE.
REQ-022 In ACCESS, mem_Address = latched address; mem_ReadCtrl = 1 for reads, 0 for writes.
REQ-023 mem_WriteCtrl = 1 only in the last ACCESS cycle of a write (exactly one clk edge); mem_WriteData = latched d_wdata.
REQ-024 Read data captured from mem_OutputData on the ACCESS->RESP edge into owner's rdata register.
REQ-025 Owner's ack high for exactly the RESP cycle; other port's ack stays 0.
REQ-026 Latency: req sampled in IDLE at edge N -> ack high during cycle after edge N+LAT (LAT+1 cycles).
REQ-027 Throughput: back-to-back transactions every LAT+2 cycles; next grant sampled in IDLE after RESP.
REQ-028 Requesters hold req/addr/data until ack; request changes after grant ignored, transaction completes and acks regardless.
REQ-029 Loser's req remains pending and is granted at the next IDLE unless outranked again.
REQ-030 ACCESS counter 4 bits, cleared on entry, never wraps beyond LAT-1.
REQ-031 Outside ACCESS, mem_ReadCtrl = mem_WriteCtrl = 0; mem_Address holds last value.

Reset
REQ-032 rst_n low asynchronously forces IDLE, counter 0, all acks/strobes/busy/grant_d 0, rdata and mem_Address/mem_WriteData 0.
REQ-033 Reset mid-ACCESS aborts the transaction: no write strobe, no ack; first grant evaluated on first edge with rst_n high.

Configuration
REQ-034 With MEM_PORT_ARBITER_RR_EN defined, simultaneous requests alternate: the port not granted last (per grant_d) wins; first contention after reset goes to data.
REQ-035 Without MEM_PORT_ARBITER_RR_EN, fixed data-over-instruction priority per REQ-021; single requests unaffected either way.

Verification
REQ-036 LAT=1, i_req, i_addr=4, mem[4]=0x8C220000 -> i_ack 2 cycles after request, i_rdata=0x8C220000, no write strobe.
REQ-037 d_req, d_we=1, d_addr=9, d_wdata=0x00010001 -> single mem_WriteCtrl pulse at address 9, d_ack next cycle; subsequent read of 9 returns 0x00010001.
REQ-038 i_req and d_req both held 3 transactions, LAT=2, fixed priority -> three d_acks, zero i_acks; with RR_EN -> order d,i,d.
REQ-039 LAT=3, rst_n low in second ACCESS cycle of write to address 5 -> mem[5] unchanged, no ack, busy=0 immediately.
REQ-040 d_req dropped one cycle after grant -> transaction completes, d_ack pulses once, FSM back to IDLE.
